// File: rtl/gate_pkg.sv
// Shared definitions for the logic-cell library (and_gate, or_gate, xor_gate).
//   GATE_WIDTH_DEF : default operand/result width
//   GATE_CNT_W_DEF : default width of the activity counter
//   sat_inc()      : saturating increment on a 64-bit carrier; callers
//                    zero-extend their counter and cast the result back.
package gate_pkg;

  localparam int GATE_WIDTH_DEF = 1;
  localparam int GATE_CNT_W_DEF = 16;

  // Returns val+1, or val unchanged once it has reached max_val.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] max_val);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/gate_activity_mon.sv
// Activity monitor shared by the gate cells: counts the clock edges on which
// a sampled lane rises 0->1, saturating at all-ones.
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset
//   lane0    : lane being watched (sampled at each rising edge)
//   rise_cnt : saturating count of sampled rises
//   cnt_sat  : high while rise_cnt is all-ones
module gate_activity_mon
  import gate_pkg::*;
#(
  parameter int CNT_W = GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lane0,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_sat
);

  localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

  logic prev0;
  logic rise;

  // prev0 resets to 0, so a 1 on the first edge after reset counts as a rise.
  assign rise = lane0 & ~prev0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev0    <= 1'b0;
      rise_cnt <= '0;
    end else begin
      prev0 <= lane0;
      if (rise) begin
        rise_cnt <= CNT_W'(sat_inc(64'(rise_cnt), CNT_MAX));
      end
    end
  end

  assign cnt_sat = &rise_cnt;

endmodule

// File: rtl/and_gate.sv
// Bitwise two-input AND cell with a registered copy of the result and a
// lane-0 rising-edge activity counter for debug observability.
//   x, y     : operands (WIDTH bits)
//   z        : combinational x & y, independent of clk/rst
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset
//   z_q      : result registered one cycle after z
//   rise_cnt : saturating count of lane-0 result rises
//   cnt_sat  : high while rise_cnt is all-ones
// x, y, z come first so the cell instantiates positionally as a plain gate.
module and_gate
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH_DEF,
  parameter int CNT_W = GATE_CNT_W_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] z_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_sat
);

  assign z = x & y;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

  gate_activity_mon #(
    .CNT_W (CNT_W)
  ) u_mon (
    .clk      (clk),
    .rst      (rst),
    .lane0    (z[0]),
    .rise_cnt (rise_cnt),
    .cnt_sat  (cnt_sat)
  );

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1: WIDTH=1, CNT_W=16
  logic        x1, y1, z1, rst1, zq1, sat1;
  logic [15:0] cnt1;
  // duts: WIDTH=1, CNT_W=3 (saturation)
  logic        xs, ys, zs, rsts, zqs, sats;
  logic [2:0]  cnts;
  // dut8: WIDTH=8, CNT_W=16
  logic [7:0]  x8, y8, z8, zq8;
  logic        rst8, sat8;
  logic [15:0] cnt8;

  and_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
    .x(x1), .y(y1), .z(z1), .clk(clk), .rst(rst1),
    .z_q(zq1), .rise_cnt(cnt1), .cnt_sat(sat1));

  and_gate #(.WIDTH(1), .CNT_W(3)) duts (
    .x(xs), .y(ys), .z(zs), .clk(clk), .rst(rsts),
    .z_q(zqs), .rise_cnt(cnts), .cnt_sat(sats));

  and_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
    .x(x8), .y(y8), .z(z8), .clk(clk), .rst(rst8),
    .z_q(zq8), .rise_cnt(cnt8), .cnt_sat(sat8));

  int total = 0;
  int bad   = 0;

  // Reference model: per DUT, the history of sampled lane-0 results since the
  // last reset edge, plus the expected registered result.
  bit         h1[$], hs[$], h8[$];
  logic       ezq1 = 1'b0, ezqs = 1'b0;
  logic [7:0] ezq8 = 8'h00;

  function automatic int rises(input bit h[$]);
    int n = 0;
    foreach (h[i]) begin
      if (h[i] && (i == 0 || !h[i-1])) n++;
    end
    return n;
  endfunction

  function automatic longint sat_model(input int n, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (longint'(n) > m) ? m : longint'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst1) begin h1.delete(); ezq1 = 1'b0; end
    else begin h1.push_back(x1 & y1); ezq1 = x1 & y1; end
    if (rsts) begin hs.delete(); ezqs = 1'b0; end
    else begin hs.push_back(xs & ys); ezqs = xs & ys; end
    if (rst8) begin h8.delete(); ezq8 = 8'h00; end
    else begin h8.push_back(x8[0] & y8[0]); ezq8 = x8 & y8; end
  endtask

  task automatic check_all();
    longint e;
    chk("z1", 64'(z1), 64'(x1 & y1));
    chk("zq1", 64'(zq1), 64'(ezq1));
    e = sat_model(rises(h1), 16);
    chk("cnt1", 64'(cnt1), e);
    chk("sat1", 64'(sat1), 64'(e == 65535));
    chk("zs", 64'(zs), 64'(xs & ys));
    chk("zqs", 64'(zqs), 64'(ezqs));
    e = sat_model(rises(hs), 3);
    chk("cnts", 64'(cnts), e);
    chk("sats", 64'(sats), 64'(e == 7));
    chk("z8", 64'(z8), 64'(x8 & y8));
    chk("zq8", 64'(zq8), 64'(ezq8));
    e = sat_model(rises(h8), 16);
    chk("cnt8", 64'(cnt8), e);
    chk("sat8", 64'(sat8), 64'(e == 65535));
  endtask

  // Drive at the negedge, let one rising edge happen, check at the next negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst1 = 1'b1; rsts = 1'b1; rst8 = 1'b1;
    x1 = 1'b0; y1 = 1'b0; xs = 1'b0; ys = 1'b0; x8 = 8'h00; y8 = 8'h00;

    // Combinational truth-table sequence, 20 ns steps (held in reset: z ignores rst)
    #1  chk("comb_t0", 64'(z1), 64'd0);
    #19 x1 = 1'b1;
    #1  chk("comb_t20", 64'(z1), 64'd0);
    #19 y1 = 1'b1;
    #1  chk("comb_t40", 64'(z1), 64'd1);
    #19 y1 = 1'b0;
    #1  chk("comb_t60", 64'(z1), 64'd0);
    #19 x1 = 1'b1;
    #1  chk("comb_t80", 64'(z1), 64'd0);
    #39 chk("comb_t120", 64'(z1), 64'd0);

    // Reset held 3 clocks with result 1
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b1; rst1 = 1'b1;
    #1 chk("rst_z", 64'(z1), 64'd1);
    repeat (3) begin
      step();
      chk("rst_zq", 64'(zq1), 64'd0);
      chk("rst_cnt", 64'(cnt1), 64'd0);
      chk("rst_zhold", 64'(z1), 64'd1);
    end
    rst1 = 1'b0;
    step();
    chk("rel_zq", 64'(zq1), 64'd1);
    chk("rel_cnt", 64'(cnt1), 64'd1);

    // Registered latency and rise counting
    x1 = 1'b0; step();
    chk("lat_fall_zq", 64'(zq1), 64'd0);
    chk("lat_fall_cnt", 64'(cnt1), 64'd1);
    x1 = 1'b1; step();
    chk("lat_rise_zq", 64'(zq1), 64'd1);
    chk("lat_rise_cnt", 64'(cnt1), 64'd2);
    step();
    chk("lat_steady_cnt", 64'(cnt1), 64'd2);
    x1 = 1'b0; step();
    chk("lat_fall2_cnt", 64'(cnt1), 64'd2);

    // Mid-operation reset with result=1 and rise_cnt=5
    x1 = 1'b1; step();
    x1 = 1'b0; step();
    x1 = 1'b1; step();
    x1 = 1'b0; step();
    x1 = 1'b1; step();
    chk("mid_pre_cnt", 64'(cnt1), 64'd5);
    rst1 = 1'b1; step();
    chk("mid_rst_cnt", 64'(cnt1), 64'd0);
    chk("mid_rst_zq", 64'(zq1), 64'd0);
    rst1 = 1'b0; step();
    chk("mid_post_cnt", 64'(cnt1), 64'd1);
    chk("mid_post_zq", 64'(zq1), 64'd1);

    // Saturation with CNT_W=3
    rsts = 1'b0; ys = 1'b1;
    for (int i = 0; i < 9; i++) begin
      xs = 1'b1; step();
      xs = 1'b0; step();
    end
    chk("sat_cnt", 64'(cnts), 64'd7);
    chk("sat_flag", 64'(sats), 64'd1);
    xs = 1'b1; step();
    chk("sat_hold_cnt", 64'(cnts), 64'd7);
    chk("sat_hold_flag", 64'(sats), 64'd1);
    rsts = 1'b1; step();
    chk("sat_rst_cnt", 64'(cnts), 64'd0);
    chk("sat_rst_flag", 64'(sats), 64'd0);
    rsts = 1'b0;

    // Width 8: lane 0 of the result is 0, so no count
    rst8 = 1'b0; x8 = 8'hF0; y8 = 8'h3C;
    #1 chk("w8_z", 64'(z8), 64'h30);
    step();
    chk("w8_zq", 64'(zq8), 64'h30);
    chk("w8_cnt", 64'(cnt8), 64'd0);

    // Randomized stimulus against the model, with occasional resets
    for (int i = 0; i < 300; i++) begin
      x1 = 1'($urandom); y1 = 1'($urandom);
      xs = 1'($urandom); ys = ($urandom_range(0, 3) != 0);
      x8 = 8'($urandom); y8 = 8'($urandom);
      rst1 = ($urandom_range(0, 19) == 0);
      rsts = ($urandom_range(0, 29) == 0);
      rst8 = ($urandom_range(0, 19) == 0);
      #1 chk("rnd_z1", 64'(z1), 64'(x1 & y1));
      chk("rnd_z8", 64'(z8), 64'(x8 & y8));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
